// File: rtl/tdm_rx.sv
// tdm_rx: TDM serial receiver that deserialises SLOT_WIDTH-bit MSB-first slots after a 1-bit-delayed frame sync
//   bclk       : bit clock, all logic on its rising edge
//   rst_n      : synchronous active-low reset
//   wclk       : frame sync, rising edge marks a frame start
//   tdm_in     : serial TDM data
//   data_out   : last completed slot word
//   slot_idx   : slot number of data_out
//   data_valid : one-cycle pulse qualifying data_out/slot_idx
//   frame_err  : one-cycle pulse on a frame sync at an unexpected position
//   locked     : high while syncs arrive exactly FRAME_BITS apart
module tdm_rx #(
  parameter int SLOT_WIDTH = 32,
  parameter int NUM_SLOTS  = 8
) (
  input  logic                         bclk,
  input  logic                         rst_n,
  input  logic                         wclk,
  input  logic                         tdm_in,
  output logic [SLOT_WIDTH-1:0]        data_out,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
  output logic                         data_valid,
  output logic                         frame_err,
  output logic                         locked
);
  localparam int FRAME_BITS = SLOT_WIDTH * NUM_SLOTS;
  localparam int IW = $clog2(NUM_SLOTS);
  localparam int BW = $clog2(SLOT_WIDTH);
  localparam int CW = $clog2(FRAME_BITS + 2);
  typedef enum logic [1:0] {IDLE, RECV, WAIT} state_t;
  state_t state, state_nx;
  logic wclk_q, f, lsb, last, sync_ok, err_nx;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [IW-1:0] slot;
  logic [SLOT_WIDTH-1:0] sh;
  // cnt holds the number of edges since the last sync as seen on the current edge
  always_comb begin
    f = wclk & ~wclk_q;
    lsb = (state == RECV) && (bit_cnt == BW'(SLOT_WIDTH - 1));
    last = lsb && (slot == IW'(NUM_SLOTS - 1));
    sync_ok = cnt == CW'(FRAME_BITS);
    err_nx = f && (state != IDLE) && !sync_ok;
    state_nx = f ? RECV : last ? WAIT : state;
  end
  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end
  // A slot finishing on the same edge as a sync is still delivered before the restart
  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      wclk_q     <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= '0;
      slot       <= '0;
      sh         <= '0;
      data_out   <= '0;
      slot_idx   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      wclk_q     <= wclk;
      cnt        <= f ? CW'(1) : (cnt == CW'(FRAME_BITS + 1)) ? cnt : cnt + 1'b1;
      sh         <= {sh[SLOT_WIDTH-2:0], tdm_in};
      bit_cnt    <= f ? '0 : (state == RECV) ? (lsb ? '0 : bit_cnt + 1'b1) : bit_cnt;
      slot       <= f ? '0 : lsb ? slot + 1'b1 : slot;
      data_valid <= lsb;
      frame_err  <= err_nx;
      locked     <= f ? (sync_ok && state != IDLE) : locked;
      if (lsb) begin
        data_out <= {sh[SLOT_WIDTH-2:0], tdm_in};
        slot_idx <= slot;
      end
    end
  end
endmodule

// File: tb/tb_tdm_rx.sv
// tb_tdm_rx: randomized self-checking bench for tdm_rx against an edge-indexed reference model
module tb_tdm_rx;
  localparam int W = 32;
  localparam int N = 8;
  localparam int FB = W * N;
  logic bclk = 1'b0, rst_n = 1'b0, wclk = 1'b1, tdm_in = 1'b0;
  logic [W-1:0] data_out;
  logic [2:0] slot_idx;
  logic data_valid, frame_err, locked;
  tdm_rx #(.SLOT_WIDTH(W), .NUM_SLOTS(N)) dut (
    .bclk(bclk), .rst_n(rst_n), .wclk(wclk), .tdm_in(tdm_in),
    .data_out(data_out), .slot_idx(slot_idx), .data_valid(data_valid),
    .frame_err(frame_err), .locked(locked)
  );
  always #5 bclk = ~bclk;
  int checks = 0, errors = 0, vcount = 0, v0 = 0;
  logic [W-1:0] pat [N];
  // model: every sampled bit is stored by edge number; outputs follow from distance to the last sync
  bit hist [32768];
  int n = 0, lastf = 0;
  bit have = 0, prevw = 1;
  logic [W-1:0] e_data = '0;
  int e_idx = 0;
  bit e_dv = 0, e_err = 0, e_lock = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge bclk) begin
    int d;
    bit f;
    if (!rst_n) begin
      have = 0; prevw = 1; e_data = '0; e_idx = 0; e_dv = 0; e_err = 0; e_lock = 0;
    end else begin
      hist[n] = tdm_in;
      f = wclk && !prevw;
      prevw = wclk;
      d = n - lastf;
      e_dv = 0;
      e_err = 0;
      if (have && d >= W && d <= FB && d % W == 0) begin
        e_dv = 1;
        e_idx = d / W - 1;
        for (int i = 0; i < W; i++) e_data[W-1-i] = hist[n-W+1+i];
      end
      if (f) begin
        if (have) begin
          e_err = (d != FB);
          e_lock = (d == FB);
        end
        have = 1;
        lastf = n;
      end
    end
    n++;
  end
  initial forever begin
    @(posedge bclk);
    #1;
    chk("data_valid", data_valid, e_dv);
    chk("frame_err", frame_err, e_err);
    chk("locked", locked, e_lock);
    chk("data_out", data_out, e_data);
    chk("slot_idx", slot_idx, e_idx);
    if (data_valid === 1'b1) vcount++;
  end
  task automatic cyc(input logic r, input logic w, input logic d);
    @(negedge bclk);
    rst_n = r; wclk = w; tdm_in = d;
  endtask
  // eerr/elock/expp < 0 skip the literal checks; expp is the pulse count of the preceding frame
  task automatic frame(input int gap, input bit lit, input int eerr, input int elock, input int expp);
    int hi;
    hi = $urandom_range(1, 4);
    cyc(1, 1, 1'($urandom));
    @(posedge bclk);
    #2;
    if (eerr >= 0) chk("frame_err_at_sync", frame_err, eerr);
    if (elock >= 0) chk("locked_at_sync", locked, elock);
    if (expp >= 0) chk("pulses_prev_frame", vcount - v0, expp);
    v0 = vcount;
    for (int j = 1; j < gap; j++) begin
      int k;
      k = j - 1;
      cyc(1, j < hi, (lit && k < FB) ? pat[k/W][W-1-k%W] : 1'($urandom));
      if (lit && (j == W || j == 2 * W)) begin
        @(posedge bclk);
        #2;
        chk("lit_valid", data_valid, 1);
        chk("lit_slot", slot_idx, j / W - 1);
        chk("lit_data", data_out, pat[j/W-1]);
      end
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_data_out"}, data_out, 0);
    chk({nm, "_slot_idx"}, slot_idx, 0);
    chk({nm, "_data_valid"}, data_valid, 0);
    chk({nm, "_frame_err"}, frame_err, 0);
    chk({nm, "_locked"}, locked, 0);
  endtask
  initial begin
    pat[0] = 32'hABCD0000;
    pat[1] = 32'h12345678;
    for (int i = 2; i < N; i++) pat[i] = $urandom;
    repeat (3) cyc(0, 1, 0);
    @(posedge bclk);
    #2;
    chk_zero("reset");
    repeat (40) cyc(1, 1, 1'($urandom));
    @(posedge bclk);
    #2;
    chk("no_valid_wclk_high", vcount, 0);
    repeat (5) cyc(1, 0, 1'($urandom));
    frame(256, 1, 0, 0, -1);
    frame(256, 0, 0, 1, 8);
    frame(256, 0, 0, 1, 8);
    frame(100, 0, 0, 1, 8);
    frame(256, 1, 1, 0, 3);
    frame(300, 0, 0, 1, 8);
    frame(256, 0, 1, 0, 8);
    frame(96, 0, 0, 1, 8);
    frame(140, 0, 1, 0, 3);
    cyc(0, 0, 1'($urandom));
    @(posedge bclk);
    #2;
    chk_zero("mid_reset");
    repeat (3) cyc(1, 0, 1'($urandom));
    frame(256, 1, 0, 0, -1);
    for (int i = 0; i < 12; i++)
      frame(($urandom_range(0, 2) == 0) ? $urandom_range(40, 400) : 256, 0, -1, -1, -1);
    repeat (300) cyc(1, 0, 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_rx.md
TDM_RX -- requirements
Module: tdm_rx

Interface
REQ-001 SHALL have parameter SLOT_WIDTH, default 32: bits per slot, MSB first.
REQ-002 SHALL have parameter NUM_SLOTS, default 8: slots per frame; FRAME_BITS = SLOT_WIDTH*NUM_SLOTS.
REQ-003 SHALL have port bclk, input, 1: bit clock; all logic on posedge bclk only.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port wclk, input, 1: frame sync; a rising edge marks a frame start.
REQ-006 SHALL have port tdm_in, input, 1: serial TDM data.
REQ-007 SHALL have port data_out, output, SLOT_WIDTH: last completed slot word.
REQ-008 SHALL have port slot_idx, output, clog2(NUM_SLOTS): slot number of data_out.
REQ-009 SHALL have port data_valid, output, 1: one-cycle pulse qualifying data_out/slot_idx.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a frame sync at an unexpected position.
REQ-011 SHALL have port locked, output, 1: level, high while frames arrive at exactly FRAME_BITS spacing.

Function
REQ-012 SHALL sample wclk and tdm_in on every posedge bclk; frame-start edge F = posedge where wclk samples 1 and the previous sample was 0.
REQ-013 SHALL use a 1-bit delay: the tdm_in bit sampled at edge F+1+k is slot floor(k/SLOT_WIDTH), bit SLOT_WIDTH-1-(k mod SLOT_WIDTH), for k = 0..FRAME_BITS-1.
REQ-014 SHALL use states IDLE (no sync seen since reset), RECV (capturing slots), WAIT (all slots captured, awaiting sync).
REQ-015 SHALL transition IDLE->RECV at F, RECV->WAIT after the LSB of slot NUM_SLOTS-1, and WAIT->RECV at F.
REQ-016 SHALL, on sampling the LSB of slot s at edge F+SLOT_WIDTH*(s+1), update data_out with the word and slot_idx with s, and raise data_valid for exactly the following cycle.
REQ-017 SHALL hold data_out and slot_idx stable between data_valid pulses.
REQ-018 SHALL emit data_valid for every completed slot regardless of locked.
REQ-019 SHALL count posedges since the last F in a counter that saturates at FRAME_BITS+1.
REQ-020 SHALL treat F at count == FRAME_BITS as normal, with no error.
REQ-021 SHALL treat F at count < FRAME_BITS in RECV as an early sync: discard the partial slot, pulse frame_err for one cycle, restart at slot 0 bit SLOT_WIDTH-1.
REQ-022 SHALL treat F at count > FRAME_BITS as a late sync: ignore the extra bits received in WAIT, pulse frame_err, restart at slot 0.
REQ-023 SHALL NOT flag the first F after reset (IDLE) as an error.
REQ-024 SHALL set locked when F arrives at count == FRAME_BITS, and clear it in the same cycle frame_err pulses.
REQ-025 SHALL, for a slot completed on the same edge as an F (early sync exactly on an LSB), output that slot's data_valid and also restart the frame.

Reset
REQ-026 SHALL, while rst_n is low at posedge bclk, set data_out=0, slot_idx=0, data_valid=0, frame_err=0, locked=0, state=IDLE, and all counters to 0.
REQ-027 SHALL set the stored previous wclk sample to 1 on reset, so a wclk already high at reset release does not create F.
REQ-028 SHALL, on reset asserted mid-frame, discard the partial frame and emit no data_valid for it.

Verification
REQ-029 SHALL pass: reset, wclk low then high at edge F, slot0=0xABCD0000 and slot1=0x12345678 driven from F+1 -> data_valid in the cycle after F+32 with data_out 0xABCD0000, slot_idx 0; after F+64 with data_out 0x12345678, slot_idx 1.
REQ-030 SHALL pass: two syncs 256 edges apart -> locked rises at the second F; frame_err stays 0; 8 valid pulses per frame.
REQ-031 SHALL pass: second sync at count 100 -> frame_err pulse, locked 0, slot 3 partial discarded, next data_valid at F'+32 with slot_idx 0.
REQ-032 SHALL pass: second sync at count 300 -> 8 valid pulses in the first frame, frame_err pulse at the late F, no pulses during WAIT.
REQ-033 SHALL pass: wclk held high through reset release -> no F and no data_valid until wclk goes low and then high.
REQ-034 SHALL pass: rst_n low for one cycle mid-slot 4 -> all outputs 0 next cycle, state IDLE, next F accepted with no frame_err.
